// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
//  Module   : reg_file
//  Purpose  : NREGS x XLEN integer register file for the multicycle RISC-V
//             datapath. One synchronous write port, two combinational read
//             ports, x0 hardwired to zero, optional write-to-read bypass.
//  Revision : 1.0 - initial release
// ============================================================================
module reg_file #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int BYPASS = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            regWrite,
    input  logic [4:0]      writeReg,
    input  logic [XLEN-1:0] writeData,
    input  logic [4:0]      readReg1,
    input  logic [4:0]      readReg2,
    output logic [XLEN-1:0] readData1,
    output logic [XLEN-1:0] readData2
);

    // x0 has no storage at all; entries 1..NREGS-1 are real flops.
    logic [XLEN-1:0] regs_q [1:NREGS-1];
    logic [XLEN-1:0] regs_d [1:NREGS-1];
    logic            w_wr_en;

    // A write is effective only for a non-zero, in-range destination, so
    // neither x0 nor an out-of-range index can be written or bypassed.
    assign w_wr_en = regWrite && (writeReg != 5'd0) && (int'(writeReg) < NREGS);

    // Next-state: the addressed entry takes writeData, all others hold.
    always_comb begin
        for (int i = 1; i < NREGS; i++) begin
            regs_d[i] = (w_wr_en && (writeReg == 5'(i))) ? writeData : regs_q[i];
        end
    end

    // Storage: asynchronous clear dominates any write at the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Read port 1: stored value (0 for x0/out of range), optionally bypassed.
    // Bypass is suppressed during reset so the ports read 0 throughout it.
    always_comb begin
        readData1 = '0;
        for (int i = 1; i < NREGS; i++) begin
            if (readReg1 == 5'(i)) begin
                readData1 = regs_q[i];
            end
        end
        if ((BYPASS != 0) && !reset && w_wr_en && (readReg1 == writeReg)) begin
            readData1 = writeData;
        end
    end

    // Read port 2: identical structure to port 1.
    always_comb begin
        readData2 = '0;
        for (int i = 1; i < NREGS; i++) begin
            if (readReg2 == 5'(i)) begin
                readData2 = regs_q[i];
            end
        end
        if ((BYPASS != 0) && !reset && w_wr_en && (readReg2 == writeReg)) begin
            readData2 = writeData;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_file.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_file
//  Purpose  : Directed self-checking bench for reg_file. Three instances share
//             the stimulus: bypass enabled, bypass disabled, and a reduced
//             8-entry file without bypass.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file;

    logic        clk;
    logic        reset;
    logic        regWrite;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic [4:0]  readReg1;
    logic [4:0]  readReg2;
    logic [31:0] rd1_bp, rd2_bp;
    logic [31:0] rd1_nb, rd2_nb;
    logic [31:0] rd1_sm, rd2_sm;

    int n_checks = 0;
    int n_fail   = 0;

    reg_file #(.XLEN(32), .NREGS(32), .BYPASS(1)) dut (
        .clk(clk), .reset(reset), .regWrite(regWrite), .writeReg(writeReg),
        .writeData(writeData), .readReg1(readReg1), .readReg2(readReg2),
        .readData1(rd1_bp), .readData2(rd2_bp)
    );

    reg_file #(.XLEN(32), .NREGS(32), .BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset), .regWrite(regWrite), .writeReg(writeReg),
        .writeData(writeData), .readReg1(readReg1), .readReg2(readReg2),
        .readData1(rd1_nb), .readData2(rd2_nb)
    );

    reg_file #(.XLEN(32), .NREGS(8), .BYPASS(0)) dut_sm (
        .clk(clk), .reset(reset), .regWrite(regWrite), .writeReg(writeReg),
        .writeData(writeData), .readReg1(readReg1), .readReg2(readReg2),
        .readData1(rd1_sm), .readData2(rd2_sm)
    );

    // 10 ns clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge and settle 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] idx, input logic [31:0] val);
        regWrite  = 1'b1;
        writeReg  = idx;
        writeData = val;
        tick();
        regWrite  = 1'b0;
    endtask

    initial begin
        reset = 1'b1; regWrite = 1'b0; writeReg = '0; writeData = '0;
        readReg1 = 5'd5; readReg2 = 5'd0;
        tick(); tick();
        reset = 1'b0;
        #1;
        check_val("reset_state_rd1", rd1_bp, 32'h0);
        check_val("reset_state_rd2", rd2_bp, 32'h0);

        // Async reset clears with no clock edge.
        wr(5'd5, 32'hDEADBEEF);
        check_val("x5_written", rd1_bp, 32'hDEADBEEF);
        reset = 1'b1;
        #1;
        check_val("async_reset_during", rd1_bp, 32'h0);
        check_val("async_reset_during_nb", rd1_nb, 32'h0);
        #2;
        reset = 1'b0;
        #1;
        check_val("async_reset_after", rd1_bp, 32'h0);

        // Basic write/read on both ports.
        wr(5'd10, 32'd200000);
        readReg1 = 5'd10; readReg2 = 5'd10;
        #1;
        check_val("basic_rd1", rd1_bp, 32'd200000);
        check_val("basic_rd2", rd2_bp, 32'd200000);
        check_val("basic_rd1_nb", rd1_nb, 32'd200000);

        // x0 protection, bypass must not fire for x0.
        regWrite = 1'b1; writeReg = 5'd0; writeData = 32'hFFFFFFFF;
        readReg1 = 5'd0; readReg2 = 5'd0;
        #1;
        check_val("x0_no_bypass", rd1_bp, 32'h0);
        tick();
        regWrite = 1'b0;
        check_val("x0_after_edge", rd1_bp, 32'h0);
        check_val("x0_after_edge_nb", rd2_nb, 32'h0);

        // Write enable low leaves x3 alone.
        wr(5'd3, 32'd7);
        regWrite = 1'b0; writeReg = 5'd3; writeData = 32'd99; readReg1 = 5'd3;
        tick();
        check_val("we_low_hold", rd1_bp, 32'd7);
        check_val("we_low_hold_nb", rd1_nb, 32'd7);

        // Bypass behaviour on port 2, port 1 on an unrelated register.
        wr(5'd5, 32'h0000_5555);
        wr(5'd4, 32'd1);
        regWrite = 1'b1; writeReg = 5'd4; writeData = 32'd42;
        readReg1 = 5'd5; readReg2 = 5'd4;
        #1;
        check_val("bypass_pre_edge", rd2_bp, 32'd42);
        check_val("nobypass_pre_edge", rd2_nb, 32'd1);
        check_val("bypass_port1_unaffected", rd1_bp, 32'h0000_5555);
        tick();
        regWrite = 1'b0;
        check_val("nobypass_post_edge", rd2_nb, 32'd42);
        check_val("bypass_post_edge", rd2_bp, 32'd42);

        // Both ports bypass simultaneously.
        regWrite = 1'b1; writeReg = 5'd6; writeData = 32'h0000_1234;
        readReg1 = 5'd6; readReg2 = 5'd6;
        #1;
        check_val("dual_bypass_rd1", rd1_bp, 32'h0000_1234);
        check_val("dual_bypass_rd2", rd2_bp, 32'h0000_1234);
        check_val("dual_nobypass_rd1", rd1_nb, 32'h0);
        tick();
        regWrite = 1'b0;

        // Reset beats a concurrent write, then normal write resumes.
        reset = 1'b1; regWrite = 1'b1; writeReg = 5'd8; writeData = 32'd55;
        tick();
        reset = 1'b0; regWrite = 1'b0; readReg1 = 5'd8; readReg2 = 5'd10;
        #1;
        check_val("reset_beats_write", rd1_bp, 32'h0);
        check_val("reset_clears_x10", rd2_bp, 32'h0);
        wr(5'd8, 32'd55);
        check_val("write_after_reset", rd1_bp, 32'd55);

        // Back-to-back writes: last wins.
        wr(5'd9, 32'd1);
        wr(5'd9, 32'd2);
        readReg1 = 5'd9;
        #1;
        check_val("back_to_back", rd1_bp, 32'd2);

        // Reduced file: out-of-range writes dropped, must not alias x4.
        wr(5'd4, 32'd42);
        wr(5'd12, 32'h0000_0ABC);
        readReg1 = 5'd12; readReg2 = 5'd4;
        #1;
        check_val("full_x12", rd1_bp, 32'h0000_0ABC);
        check_val("small_oor_read", rd1_sm, 32'h0);
        check_val("small_no_alias", rd2_sm, 32'd42);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Safety net so the bench can never hang.
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
